// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared 8-bit binary-to-BCD converter; optional leading-zero blank flags via BCD_CONV_ARB_BLANK_EN.
// Latency: grant at edge N, rsp_valid in N+2; rsp_ready low holds RESP and blocks all grants.
module bcd_conv_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_bin,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [11:0]       rsp_bcd,
`ifdef BCD_CONV_ARB_BLANK_EN
    output logic [2:0]        rsp_blank,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_last;
    logic [IDW-1:0]   r_id;
    logic [7:0]       r_bin;
    logic [11:0]      r_bcd;
    logic             r_rsp_valid;
    logic             r_busy;
    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic [11:0]      w_bcd;
`ifdef BCD_CONV_ARB_BLANK_EN
    logic [2:0]       r_blank;
    logic [2:0]       w_blank;
`endif

    function automatic logic [11:0] dabble(input logic [7:0] bin);
        logic [19:0] s;
        s = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (s[11:8]  >= 4'd5) s[11:8]  = s[11:8]  + 4'd3;
            if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
            if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
            s = s << 1;
        end
        return s[19:8];
    endfunction

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_last) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_last) + k) % NREQ);
            end
        end
    end

    assign w_bcd = dabble(r_bin);
`ifdef BCD_CONV_ARB_BLANK_EN
    assign w_blank = {w_bcd[11:8] == 4'd0, w_bcd[11:4] == 8'd0, 1'b0};
`endif

    always_comb begin
        req_ready = '0;
        if (r_state == IDLE && w_found) req_ready[w_win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef BCD_CONV_ARB_BLANK_EN
            r_blank     <= 3'b000;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_bin   <= req_bin[8*w_win +: 8];
                        r_id    <= w_win;
                        r_last  <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_bcd       <= w_bcd;
`ifdef BCD_CONV_ARB_BLANK_EN
                    r_blank     <= w_blank;
`endif
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_bcd   = r_bcd;
    assign busy      = r_busy;
`ifdef BCD_CONV_ARB_BLANK_EN
    assign rsp_blank = r_blank;
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed plus randomized bench for bcd_conv_arbiter against a decimal-arithmetic reference.
module tb_bcd_conv_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_bin;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [11:0]       rsp_bcd;
    logic              busy;
`ifdef BCD_CONV_ARB_BLANK_EN
    logic [2:0]        rsp_blank;
`endif

    int errors = 0;
    int checks = 0;
    int m_last;

    bcd_conv_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bin(req_bin),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_bcd(rsp_bcd),
`ifdef BCD_CONV_ARB_BLANK_EN
        .rsp_blank(rsp_blank),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [2:0] ref_blank(input int v);
        return {v < 100, v < 10, 1'b0};
    endfunction

    // Next requester after m_last, wrapping, that currently has req_valid high.
    function automatic int ref_winner();
        for (int k = 1; k <= NREQ; k++)
            if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        m_last = NREQ - 1;
    endtask

    // Called just after an edge in IDLE with requests already driven.
    task automatic serve(input bit stall, output int got_id);
        int w;
        int v;
        logic [11:0] held_bcd;
        logic [IDW-1:0] held_id;
        #1;
        w = ref_winner();
        chk("grant", {28'd0, req_ready}, 32'(1 << w));
        v = int'(req_bin[8*w +: 8]);
        m_last = w;
        tick();
        chk("conv_state", {29'd0, busy, rsp_valid, |req_ready}, 32'b100);
        tick();
        chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("resp_id", {30'd0, rsp_id}, 32'(w));
        chk("resp_bcd", {20'd0, rsp_bcd}, {20'd0, ref_bcd(v)});
`ifdef BCD_CONV_ARB_BLANK_EN
        chk("resp_blank", {29'd0, rsp_blank}, {29'd0, ref_blank(v)});
`endif
        got_id = int'(rsp_id);
        if (stall) begin
            held_bcd = ref_bcd(v);
            held_id  = IDW'(w);
            rsp_ready = 1'b0;
            for (int c = 0; c < 20; c++) begin
                tick();
                chk("stall_hold", {13'd0, rsp_valid, busy, |req_ready, rsp_id, rsp_bcd},
                    {13'd0, 1'b1, 1'b1, 1'b0, held_id, held_bcd});
            end
        end
        rsp_ready = 1'b1;
        tick();
        chk("back_idle", {30'd0, busy, rsp_valid}, 32'd0);
    endtask

    initial begin
        int id;
        int r;
        rst_n = 1'b0;
        req_valid = '0;
        req_bin = '0;
        rsp_ready = 1'b0;

        // Reset and idle: everything zero for ten cycles, rsp_ready toggling harmlessly.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            rsp_ready = c[0];
            #1;
            chk("idle_zero", {15'd0, req_ready, rsp_valid, rsp_id, rsp_bcd, busy}, 32'd0);
`ifdef BCD_CONV_ARB_BLANK_EN
            chk("idle_blank", {29'd0, rsp_blank}, 32'd0);
`endif
            tick();
        end
        rsp_ready = 1'b1;

        // Single conversion from requester 2.
        req_valid = 4'b0100;
        req_bin = '0;
        req_bin[23:16] = 8'd173;
        serve(1'b0, id);
        chk("single_id", 32'(id), 32'd2);
        req_valid = '0;

        // Every value through requester 0.
        req_valid = 4'b0001;
        for (int v = 0; v < 256; v++) begin
            req_bin[7:0] = 8'(v);
            serve(1'b0, id);
        end
        req_valid = '0;

        // Fairness: all valid from reset, grants must rotate 0,1,2,3.
        do_reset();
        rsp_ready = 1'b1;
        req_bin = {8'd40, 8'd30, 8'd20, 8'd10};
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            serve(1'b0, id);
            chk("rr_order", 32'(id), 32'(k % NREQ));
        end

        // Back-pressure with requests still pending; next grant must follow immediately.
        serve(1'b1, id);
        serve(1'b0, id);
        req_valid = '0;

        // Reset in CONV, then in RESP.
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            rsp_ready = 1'b1;
            req_valid = 4'b0100;
            req_bin[23:16] = 8'd99;
            tick();
            if (ph == 1) tick();
            rst_n = 1'b0;
            req_valid = '0;
            tick();
            rst_n = 1'b1;
            m_last = NREQ - 1;
            chk("abort_clear", {30'd0, rsp_valid, busy}, 32'd0);
            for (int c = 0; c < 5; c++) begin
                tick();
                chk("abort_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);
            end
            req_valid = 4'b1111;
            serve(1'b0, id);
            chk("abort_next_id", 32'(id), 32'd0);
            req_valid = '0;
        end

        // Random traffic: granted requester reloads with a fresh random request.
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) req_bin[8*i +: 8] = 8'($urandom_range(0, 255));
        req_valid = 4'($urandom_range(1, 15));
        for (int t = 0; t < 200; t++) begin
            serve(1'b0, id);
            req_bin[8*id +: 8] = 8'($urandom_range(0, 255));
            req_valid[id] = 1'($urandom_range(0, 1));
            if (req_valid == '0) begin
                r = $urandom_range(0, NREQ - 1);
                req_valid[r] = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
